// File: rtl/prog_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prog_loader_pkg                                                 |
// | Desc     : Shared types and constants for the program loader.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         MEM_DEPTH = 16;
  localparam int         ADDR_W    = 4;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_LOAD = 3'd1,
    ST_CSUM = 3'd2,
    ST_HOLD = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  // Power-up program image, generated from asm.txt.
  localparam logic [7:0] ASM_IMAGE [MEM_DEPTH] = '{
    8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87,
    8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'h0F
  };

endpackage
`default_nettype wire

// File: rtl/prog_loader_uart_rx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_byte                                                    |
// | Desc     : 8N1 UART receiver: synchroniser, mid-bit sampling, LSB first.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1_q, sync2_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A low stop bit must not be mistaken for the next start bit.
      RX_BREAK: begin
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_valid = valid_q;
  assign rx_data  = shift_q;
  assign rx_ferr  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prog_loader                                                     |
// | Desc     : 16x8 instruction memory with UART program download and CPU     |
// |            reset control. Define PROG_LOADER_CSUM_EN to add a checksum.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20,
  parameter int HOLD_W       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        dout,
  output logic              cpu_reset,
  output logic              loading,
  output logic              load_err
);

  localparam int                 TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int                 TMO_W      = $clog2(TMO_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TMO_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = '1;
  localparam logic [ADDR_W-1:0] WPTR_LAST  = ADDR_W'(MEM_DEPTH - 1);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ferr;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif
  logic              mem_we;
  logic [7:0]        mem_q [MEM_DEPTH] = ASM_IMAGE;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_HOLD;
      wptr_q  <= '0;
      tmo_q   <= '0;
      hold_q  <= '0;
`ifdef PROG_LOADER_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
`ifdef PROG_LOADER_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Memory keeps its contents across reset; only the loader writes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q] <= rx_data;
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    tmo_d   = '0;
    hold_d  = '0;
    mem_we  = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ST_RUN, ST_ERR: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
`ifdef PROG_LOADER_CSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (rx_valid) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
`ifdef PROG_LOADER_CSUM_EN
          sum_d  = sum_q + rx_data;
          if (wptr_q == WPTR_LAST) state_d = ST_CSUM;
`else
          if (wptr_q == WPTR_LAST) state_d = ST_HOLD;
`endif
        end else if (rx_ferr || (tmo_q == TMO_LAST)) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`ifdef PROG_LOADER_CSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          state_d = (rx_data == sum_q) ? ST_HOLD : ST_ERR;
        end else if (rx_ferr || (tmo_q == TMO_LAST)) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  assign dout      = mem_q[addr];
  assign cpu_reset = (state_q == ST_RUN);
  assign loading   = (state_q == ST_LOAD);
  assign load_err  = (state_q == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_prog_loader                                                  |
// | Desc     : Directed bench for prog_loader (PROG_LOADER_CSUM_EN aware).     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_prog_loader;

  localparam int CPB = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rxd   = 1'b1;
  logic [3:0] addr  = 4'd0;
  logic [7:0] dout;
  logic       cpu_reset, loading, load_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_mem   [16];
  logic [7:0] frame_buf [16];

  always #5 clk = ~clk;

  prog_loader #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_BITS (20),
    .HOLD_W       (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .addr      (addr),
    .dout      (dout),
    .cpu_reset (cpu_reset),
    .loading   (loading),
    .load_err  (load_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      bit_time();
    end
    rxd = stop_bit;
    bit_time();
    rxd = 1'b1;
    bit_time();
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), {24'd0, dout}, {24'd0, exp_mem[i]});
    end
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (!cpu_reset && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, {31'd0, cpu_reset}, 32'd1);
  endtask

  task automatic count_hold(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!cpu_reset && n < 64);
    chk(tag, n, 32'd16);
  endtask

  task automatic send_frame(input logic bad_csum);
    logic [7:0] sum;
    sum = 8'h00;
    send_byte(8'hA5, 1'b1);
    chk("sync_loading", {31'd0, loading}, 32'd1);
    chk("sync_cpu_held", {31'd0, cpu_reset}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      send_byte(frame_buf[i], 1'b1);
      exp_mem[i] = frame_buf[i];
      sum = sum + frame_buf[i];
      chk("load_cpu_held", {31'd0, cpu_reset}, 32'd0);
      chk((i < 15) ? "load_loading" : "load_done", {31'd0, loading}, (i < 15) ? 32'd1 : 32'd0);
    end
`ifdef PROG_LOADER_CSUM_EN
    send_byte(bad_csum ? (sum ^ 8'h01) : sum, 1'b1);
`else
    if (bad_csum) sum = 8'h00;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_mem = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87,
                8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'h0F};

    // Power-up: held in reset, then a 16-cycle stretch.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("rst_loading",   {31'd0, loading},   32'd0);
    chk("rst_load_err",  {31'd0, load_err},  32'd0);
    reset = 1'b1;
    count_hold("por_hold_len");
    check_mem("asm_image");

`ifdef PROG_LOADER_CSUM_EN
    for (int i = 0; i < 16; i++) frame_buf[i] = 8'h11;
    send_frame(1'b0);
    wait_run("csum_ok_run");
    chk("csum_ok_err", {31'd0, load_err}, 32'd0);
    check_mem("csum_ok_mem");

    send_frame(1'b1);
    repeat (40) @(posedge clk);
    #1;
    chk("csum_bad_err", {31'd0, load_err}, 32'd1);
    chk("csum_bad_cpu", {31'd0, cpu_reset}, 32'd0);
`endif

    for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i);
    send_frame(1'b0);
    chk("post_load_held", {31'd0, cpu_reset}, 32'd0);
    wait_run("load_run");
    chk("load_run_err", {31'd0, load_err}, 32'd0);
    check_mem("load_mem");

    // Timeout after a partial load.
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h30 + 8'(i), 1'b1);
      exp_mem[i] = 8'h30 + 8'(i);
    end
    repeat (100) @(posedge clk);
    #1;
    chk("tmo_before_err",  {31'd0, load_err}, 32'd0);
    chk("tmo_before_load", {31'd0, loading},  32'd1);
    repeat (80) @(posedge clk);
    #1;
    chk("tmo_err",     {31'd0, load_err},  32'd1);
    chk("tmo_cpu",     {31'd0, cpu_reset}, 32'd0);
    chk("tmo_loading", {31'd0, loading},   32'd0);
    check_mem("tmo_mem");

    // Framing error on the third data byte.
    send_byte(8'hA5, 1'b1);
    chk("resync_err",     {31'd0, load_err}, 32'd0);
    chk("resync_loading", {31'd0, loading},  32'd1);
    send_byte(8'h5A, 1'b1);
    exp_mem[0] = 8'h5A;
    send_byte(8'h6B, 1'b1);
    exp_mem[1] = 8'h6B;
    send_byte(8'h77, 1'b0);
    chk("ferr_err", {31'd0, load_err},  32'd1);
    chk("ferr_cpu", {31'd0, cpu_reset}, 32'd0);
    check_mem("ferr_mem");

    for (int i = 0; i < 16; i++) frame_buf[i] = 8'hC0 + 8'(i);
    send_frame(1'b0);
    wait_run("recover_run");
    send_byte(8'h77, 1'b0);
    chk("run_ferr_cpu",  {31'd0, cpu_reset}, 32'd1);
    chk("run_ferr_load", {31'd0, loading},   32'd0);
    chk("run_ferr_err",  {31'd0, load_err},  32'd0);

    // Reset in the middle of the ninth data byte.
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'hE0 + 8'(i), 1'b1);
      exp_mem[i] = 8'hE0 + 8'(i);
    end
    rxd = 1'b0;
    bit_time();
    bit_time();
    bit_time();
    reset = 1'b0;
    rxd   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_cpu",     {31'd0, cpu_reset}, 32'd0);
    chk("abort_loading", {31'd0, loading},   32'd0);
    chk("abort_err",     {31'd0, load_err},  32'd0);
    reset = 1'b1;
    count_hold("abort_hold_len");
    check_mem("abort_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
